ram_param: RTL

RAM_PARAM -- requirements
Module: ram_param

---
 rtl/ram_param_if.sv | 20 ++
 rtl/ram_param.sv | 64 ++++++
 2 files changed

// File: rtl/ram_param_if.sv
// Bus bundle for ram_param: write/read request from the master, read data and busy from the RAM.
// state_dbg mirrors the clear controller state (1 = CLEAR) for checkers.
interface ram_param_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 9
) ();
  logic                 load;
  logic [ADDR_BITS-1:0] address;
  logic [WIDTH-1:0]     in;
  logic [WIDTH-1:0]     out;
  logic                 busy;
  logic                 state_dbg;

  // Handshake: no valid/ready pair. A write is accepted on any rising clk where
  // load=1 and busy=0; reads are combinational and valid whenever busy=0.
  modport master (output load, output address, output in,
                  input out, input busy, input state_dbg);
  modport slave  (input load, input address, input in,
                  output out, output busy, output state_dbg);
endinterface

// File: rtl/ram_param.sv
// Single-port RAM, combinational read, synchronous write.
// Optional power-on clear sweep selected by macro RAM_PARAM_CLEAR_EN.
module ram_param #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 9
) (
  input  logic        clk,
  input  logic        reset,
  ram_param_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];

`ifdef RAM_PARAM_CLEAR_EN
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t               state, state_next;
  logic [ADDR_BITS-1:0] ptr, ptr_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // ptr wraps to 0 on the same edge that clears the last word.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    if (state == CLEAR) begin
      ptr_next = ptr + 1'b1;
      if (ptr == {ADDR_BITS{1'b1}}) state_next = IDLE;
    end
  end

  // Reset freezes the array; the sweep owns it otherwise until done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) mem[ptr] <= '0;
      else if (bus.load)  mem[bus.address] <= bus.in;
    end
  end

  assign bus.busy      = (state == CLEAR);
  assign bus.state_dbg = (state == CLEAR);
  assign bus.out       = bus.busy ? '0 : mem[bus.address];
`else
  logic unused_reset;
  assign unused_reset = reset;

  always_ff @(posedge clk) begin
    if (bus.load) mem[bus.address] <= bus.in;
  end

  assign bus.busy      = 1'b0;
  assign bus.state_dbg = 1'b0;
  assign bus.out       = mem[bus.address];
`endif
endmodule
